// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster-order pixel stream to 3x3 neighbourhood windows.
// Two chained line RAMs hold the previous two lines; a 3x3 register array
// shifts on every accepted pixel. Only fully interior windows are emitted,
// one clock after the bottom-right pixel of the window is accepted.
module window_3x3_gen #(
    parameter int NB_DATA    = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic [NB_DATA-1:0]   i_pixel,
    output logic [9*NB_DATA-1:0] o_window,
    output logic                 o_valid,
    output logic                 o_eof
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [COL_W-1:0]   col, col_cur;
    logic [ROW_W-1:0]   row, row_cur;
    logic [NB_DATA-1:0] lb0 [IMG_WIDTH];
    logic [NB_DATA-1:0] lb1 [IMG_WIDTH];
    logic [NB_DATA-1:0] top_rd, mid_rd;
    // win[row][col]: row 0 = top (oldest line), col 2 = newest column
    logic [NB_DATA-1:0] win [3][3];
    logic               last_col, last_row, emit;

    // Effective position of the incoming pixel; i_sof forces (0,0)
    always_comb begin
        col_cur  = i_sof ? '0 : col;
        row_cur  = i_sof ? '0 : row;
        top_rd   = lb1[col_cur];
        mid_rd   = lb0[col_cur];
        last_col = (col_cur == COL_W'(IMG_WIDTH - 1));
        last_row = (row_cur == ROW_W'(IMG_HEIGHT - 1));
        emit     = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
    end

    // Chained line RAMs, read-first: reads above see the pre-write contents
    always_ff @(posedge clk) begin
        if (i_valid) begin
            lb0[col_cur] <= i_pixel;
            lb1[col_cur] <= mid_rd;
        end
    end

    // Position counters, window shift and registered outputs
    always_ff @(posedge clk) begin
        if (i_rst) begin
            col      <= '0;
            row      <= '0;
            o_window <= '0;
            o_valid  <= 1'b0;
            o_eof    <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
            if (i_valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row_cur + ROW_W'(1);
                end else begin
                    col <= col_cur + COL_W'(1);
                    row <= row_cur;
                end

                for (int unsigned i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= top_rd;
                win[1][2] <= mid_rd;
                win[2][2] <= i_pixel;

                // Packed from the pre-shift columns plus the new column, so the
                // window is registered in the same cycle the pixel is accepted
                if (emit) begin
                    o_valid  <= 1'b1;
                    o_eof    <= last_row && last_col;
                    o_window <= {win[0][1], win[0][2], top_rd,
                                 win[1][1], win[1][2], mid_rd,
                                 win[2][1], win[2][2], i_pixel};
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks on a 4x4 instance and a 5x3 instance.
module tb_window_3x3_gen;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        valid_a, valid_b, sof_in;
    logic [7:0]  pix;
    logic [71:0] win_a, win_b;
    logic        ov_a, ov_b, eof_a, eof_b;

    int n_tests = 0;
    int n_fail  = 0;
    int win_cnt, eof_cnt;
    logic [71:0] first_w, last_w;
    logic [7:0]  img [0:4][0:4];

    always #5 clk = ~clk;

    window_3x3_gen #(.NB_DATA(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .i_rst(i_rst), .i_valid(valid_a), .i_sof(sof_in),
        .i_pixel(pix), .o_window(win_a), .o_valid(ov_a), .o_eof(eof_a)
    );

    window_3x3_gen #(.NB_DATA(8), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk(clk), .i_rst(i_rst), .i_valid(valid_b), .i_sof(sof_in),
        .i_pixel(pix), .o_window(win_b), .o_valid(ov_b), .o_eof(eof_b)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_seq(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = 8'(r * w + c);
    endtask

    // Drive one pixel (row r, col c of img) into the selected instance,
    // check the registered response, then idle for gap cycles.
    task automatic push(input bit sel, input int r, input int c, input logic sof, input int gap);
        logic        exp_v, got_v, got_e;
        logic [71:0] got_w, exp_w;
        int          lr, lc;
        lr = sel ? 2 : 3;
        lc = sel ? 4 : 3;
        pix    = img[r][c];
        sof_in = sof;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0; sof_in = 1'b0;
        got_v = sel ? ov_b  : ov_a;
        got_e = sel ? eof_b : eof_a;
        got_w = sel ? win_b : win_a;
        exp_v = (r >= 2) && (c >= 2);
        check($sformatf("o_valid r%0d c%0d", r, c), {71'b0, got_v}, {71'b0, exp_v});
        check($sformatf("o_eof r%0d c%0d", r, c), {71'b0, got_e},
              {71'b0, exp_v && (r == lr) && (c == lc)});
        if (exp_v) begin
            exp_w = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                     img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                     img[r][c-2],   img[r][c-1],   img[r][c]};
            check($sformatf("o_window r%0d c%0d", r, c), got_w, exp_w);
        end
        if (got_v) begin
            if (win_cnt == 0) first_w = got_w;
            last_w = got_w;
            win_cnt++;
        end
        if (got_e) eof_cnt++;
        repeat (gap) begin
            @(posedge clk); #1;
            check("gap o_valid", {71'b0, (sel ? ov_b : ov_a)}, 72'd0);
        end
    endtask

    task automatic run_frame(input bit sel, input int w, input int h, input int maxgap, input logic use_sof);
        win_cnt = 0;
        eof_cnt = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                push(sel, r, c, use_sof && (r == 0) && (c == 0),
                     (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    initial begin
        i_rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; sof_in = 1'b0; pix = '0;
        first_w = '0; last_w = '0; win_cnt = 0; eof_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset o_valid a", {71'b0, ov_a}, 72'd0);
        check("reset o_eof a", {71'b0, eof_a}, 72'd0);
        check("reset o_window a", win_a, 72'd0);
        check("reset o_valid b", {71'b0, ov_b}, 72'd0);
        check("reset o_window b", win_b, 72'd0);
        i_rst = 1'b0;

        // Test 1: 4x4 ramp, continuous
        fill_seq(4, 4);
        run_frame(0, 4, 4, 0, 1'b1);
        check("t1 count", 72'(win_cnt), 72'd4);
        check("t1 eof count", 72'(eof_cnt), 72'd1);
        check("t1 first", first_w, 72'h000102_040506_08090A);
        check("t1 last", last_w, 72'h050607_090A0B_0D0E0F);

        // Test 2: same frame with random idle gaps
        run_frame(0, 4, 4, 2, 1'b1);
        check("t2 count", 72'(win_cnt), 72'd4);
        check("t2 first", first_w, 72'h000102_040506_08090A);
        check("t2 last", last_w, 72'h050607_090A0B_0D0E0F);

        // Test 3: 5x3 ramp on the second instance
        fill_seq(5, 3);
        run_frame(1, 5, 3, 0, 1'b1);
        check("t3 count", 72'(win_cnt), 72'd3);
        check("t3 eof count", 72'(eof_cnt), 72'd1);
        check("t3 first", first_w, 72'h000102_050607_0A0B0C);
        check("t3 last", last_w, 72'h020304_070809_0C0D0E);

        // Test 4: alternating signed extremes
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = ((r * 4 + c) % 2 == 1) ? 8'h7F : 8'h80;
        run_frame(0, 4, 4, 0, 1'b1);
        check("t4 count", 72'(win_cnt), 72'd4);
        check("t4 first", first_w, 72'h807F80_807F80_807F80);

        // Test 5: abort after 6 pixels with a fresh i_sof
        fill_seq(4, 4);
        win_cnt = 0; eof_cnt = 0;
        for (int i = 0; i < 6; i++) push(0, i / 4, i % 4, i == 0, 0);
        check("t5 aborted windows", 72'(win_cnt), 72'd0);
        run_frame(0, 4, 4, 0, 1'b1);
        check("t5 count", 72'(win_cnt), 72'd4);
        check("t5 eof count", 72'(eof_cnt), 72'd1);
        check("t5 first", first_w, 72'h000102_040506_08090A);

        // Test 6: reset after pixel 9, then a new frame without i_sof
        for (int i = 0; i < 10; i++) push(0, i / 4, i % 4, i == 0, 0);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        check("t6 rst o_valid", {71'b0, ov_a}, 72'd0);
        check("t6 rst o_window", win_a, 72'd0);
        @(posedge clk); #1;
        check("t6 idle o_valid", {71'b0, ov_a}, 72'd0);
        run_frame(0, 4, 4, 0, 1'b0);
        check("t6 count", 72'(win_cnt), 72'd4);
        check("t6 first", first_w, 72'h000102_040506_08090A);
        check("t6 last", last_w, 72'h050607_090A0B_0D0E0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
